// File: rtl/fft_io_sequencer.sv
// Frame-level I/O controller for the FFT core.
// Loads one frame of ADC samples into the core's four RAM banks, pulses the
// core start, waits for completion, then streams the real-part results out
// as an indexed sample stream. The core's external address/write ports are
// only driven while the core's own controller is idle.
module fft_io_sequencer #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 17
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iARM,
   input  logic                    iADC_VALID,
   input  logic signed [D_BIT-2:0] iADC_DATA,
   input  logic                    iFFT_RDY,
   input  logic signed [D_BIT-1:0] iRES_RE_0,
   input  logic signed [D_BIT-1:0] iRES_RE_1,
   input  logic signed [D_BIT-1:0] iRES_RE_2,
   input  logic signed [D_BIT-1:0] iRES_RE_3,
   output logic signed [D_BIT-2:0] oDATA,
   output logic [A_BIT-1:0]        oADDR_WR_0,
   output logic [A_BIT-1:0]        oADDR_WR_1,
   output logic [A_BIT-1:0]        oADDR_WR_2,
   output logic [A_BIT-1:0]        oADDR_WR_3,
   output logic                    oWE_0,
   output logic                    oWE_1,
   output logic                    oWE_2,
   output logic                    oWE_3,
   output logic [A_BIT-1:0]        oADDR_RD_0,
   output logic [A_BIT-1:0]        oADDR_RD_1,
   output logic [A_BIT-1:0]        oADDR_RD_2,
   output logic [A_BIT-1:0]        oADDR_RD_3,
   output logic                    oSTART,
   output logic                    oRES_VALID,
   output logic signed [D_BIT-1:0] oRES_DATA,
   output logic [A_BIT+1:0]        oRES_INDEX,
   output logic                    oRES_LAST,
   output logic                    oBUSY,
   output logic                    oDONE,
   output logic                    oOVF
);

   localparam int IW = A_BIT + 2;
   localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

   // DRAIN shows the last result, FINISH carries the done pulse.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_UNLOAD,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t                  state;
   logic [IW-1:0]           wr_cnt;
   logic [IW-1:0]           rd_cnt;
   logic [IW-1:0]           pipe_idx;
   logic                    rd_active;
   logic                    pipe_valid;
   logic                    rdy_prev;
   logic [A_BIT-1:0]        wr_addr;
   logic [3:0]              we;
   logic signed [D_BIT-1:0] res_sel;

   // Write/read addresses are shared by all banks; bank selection is via WE.
   assign oADDR_WR_0 = wr_addr;
   assign oADDR_WR_1 = wr_addr;
   assign oADDR_WR_2 = wr_addr;
   assign oADDR_WR_3 = wr_addr;
   assign oWE_0      = we[0];
   assign oWE_1      = we[1];
   assign oWE_2      = we[2];
   assign oWE_3      = we[3];
   assign oADDR_RD_0 = rd_cnt[A_BIT-1:0];
   assign oADDR_RD_1 = rd_cnt[A_BIT-1:0];
   assign oADDR_RD_2 = rd_cnt[A_BIT-1:0];
   assign oADDR_RD_3 = rd_cnt[A_BIT-1:0];
   assign oBUSY      = (state != S_IDLE);

   // Pick the bank holding the point whose read address was issued last cycle.
   always_comb begin
      res_sel = iRES_RE_0;
      case (pipe_idx[IW-1:IW-2])
         2'd0:    res_sel = iRES_RE_0;
         2'd1:    res_sel = iRES_RE_1;
         2'd2:    res_sel = iRES_RE_2;
         default: res_sel = iRES_RE_3;
      endcase
   end

   // Sequencer: load, start, wait for completion edge, unload, done.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state      <= S_IDLE;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         pipe_idx   <= '0;
         pipe_valid <= 1'b0;
         rd_active  <= 1'b0;
         rdy_prev   <= 1'b0;
         wr_addr    <= '0;
         we         <= '0;
         oDATA      <= '0;
         oSTART     <= 1'b0;
         oRES_VALID <= 1'b0;
         oRES_DATA  <= '0;
         oRES_INDEX <= '0;
         oRES_LAST  <= 1'b0;
         oDONE      <= 1'b0;
         oOVF       <= 1'b0;
      end else begin
         rdy_prev <= iFFT_RDY;
         we       <= '0;
         oSTART   <= 1'b0;
         oDONE    <= 1'b0;

         // Samples arriving after the frame is complete are dropped and flagged.
         if (iADC_VALID && state != S_IDLE && state != S_LOAD) begin
            oOVF <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (iARM) begin
                  oOVF       <= 1'b0;
                  wr_cnt     <= '0;
                  rd_cnt     <= '0;
                  pipe_idx   <= '0;
                  pipe_valid <= 1'b0;
                  rd_active  <= 1'b0;
                  state      <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (iADC_VALID) begin
                  oDATA   <= iADC_DATA;
                  wr_addr <= wr_cnt[A_BIT-1:0];
                  we      <= 4'b0001 << wr_cnt[IW-1:IW-2];
                  if (wr_cnt == LAST_IDX) begin
                     state <= S_START;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end

            S_START: begin
               oSTART <= 1'b1;
               state  <= S_WAIT;
            end

            S_WAIT: begin
               // The oSTART cycle itself is excluded so a pre-existing high level never counts.
               if (!oSTART && iFFT_RDY && !rdy_prev) begin
                  rd_cnt    <= '0;
                  rd_active <= 1'b1;
                  state     <= S_UNLOAD;
               end
            end

            S_UNLOAD: begin
               pipe_valid <= rd_active;
               pipe_idx   <= rd_cnt;
               if (rd_active) begin
                  if (rd_cnt == LAST_IDX) begin
                     rd_active <= 1'b0;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
               oRES_VALID <= pipe_valid;
               oRES_LAST  <= pipe_valid && (pipe_idx == LAST_IDX);
               if (pipe_valid) begin
                  oRES_DATA  <= res_sel;
                  oRES_INDEX <= pipe_idx;
               end
               if (pipe_valid && pipe_idx == LAST_IDX) begin
                  state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               oRES_VALID <= 1'b0;
               oRES_LAST  <= 1'b0;
               pipe_valid <= 1'b0;
               oDONE      <= 1'b1;
               state      <= S_FINISH;
            end

            S_FINISH: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_io_sequencer.sv
// Testbench for fft_io_sequencer with a 16-point frame (A_BIT=2).
// A timeline model derives every expected output from event times (arm,
// last sample, start, completion edge); a small RAM model plays the core.
module tb_fft_io_sequencer;

   localparam int A_BIT    = 2;
   localparam int D_BIT    = 17;
   localparam int AW       = D_BIT - 1;
   localparam int BANK_PTS = 2 ** A_BIT;
   localparam int N        = 4 * BANK_PTS;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    arm;
   logic                    adc_valid;
   logic signed [AW-1:0]    adc_data;
   logic                    fft_rdy;
   logic signed [D_BIT-1:0] res_re_0, res_re_1, res_re_2, res_re_3;
   logic signed [AW-1:0]    oDATA;
   logic [A_BIT-1:0]        addr_wr_0, addr_wr_1, addr_wr_2, addr_wr_3;
   logic                    oWE_0, oWE_1, oWE_2, oWE_3;
   logic [A_BIT-1:0]        addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3;
   logic                    oSTART, oRES_VALID, oRES_LAST, oBUSY, oDONE, oOVF;
   logic signed [D_BIT-1:0] oRES_DATA;
   logic [A_BIT+1:0]        oRES_INDEX;

   int vectors     = 0;
   int miscompares = 0;

   // Model state and expectations for the current cycle
   int                   cyc = 0;
   bit                   model_ready = 1'b0;
   int                   mode = 0;          // 0 idle, 1 loading, 2 processing
   int                   n = 0;
   int                   t_start = -100;
   int                   t_u0 = -100;
   logic                 prev_rdy = 1'b0;
   int                   e_we, e_addr_wr, e_addr_rd, e_res, e_idx;
   logic signed [AW-1:0] e_data;
   bit                   e_start, e_valid, e_last, e_done, e_busy, e_ovf, e_rd_chk, e_zero;

   // Event log taken from the DUT for hand-computed checks
   int start_cyc, last_we_cyc, first_valid_cyc, last_cyc, done_cyc, rise_cyc;
   int res_log [N];

   fft_io_sequencer #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
      .iCLK(clk), .iRESET(reset), .iARM(arm), .iADC_VALID(adc_valid),
      .iADC_DATA(adc_data), .iFFT_RDY(fft_rdy),
      .iRES_RE_0(res_re_0), .iRES_RE_1(res_re_1), .iRES_RE_2(res_re_2), .iRES_RE_3(res_re_3),
      .oDATA(oDATA),
      .oADDR_WR_0(addr_wr_0), .oADDR_WR_1(addr_wr_1), .oADDR_WR_2(addr_wr_2), .oADDR_WR_3(addr_wr_3),
      .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
      .oADDR_RD_0(addr_rd_0), .oADDR_RD_1(addr_rd_1), .oADDR_RD_2(addr_rd_2), .oADDR_RD_3(addr_rd_3),
      .oSTART(oSTART), .oRES_VALID(oRES_VALID), .oRES_DATA(oRES_DATA),
      .oRES_INDEX(oRES_INDEX), .oRES_LAST(oRES_LAST), .oBUSY(oBUSY),
      .oDONE(oDONE), .oOVF(oOVF)
   );

   always #5 clk = ~clk;

   function automatic int ramValue(input int bank, input int addr);
      return 100 * bank + addr;
   endfunction

   // Core RAM read port stand-in: one cycle read latency.
   always @(posedge clk) begin
      res_re_0 <= D_BIT'(ramValue(0, int'(addr_rd_0)));
      res_re_1 <= D_BIT'(ramValue(1, int'(addr_rd_1)));
      res_re_2 <= D_BIT'(ramValue(2, int'(addr_rd_2)));
      res_re_3 <= D_BIT'(ramValue(3, int'(addr_rd_3)));
   end

   // Timeline model: consumes the inputs of the cycle just ended, sets expectations for the next.
   always @(posedge clk) begin
      int k;
      int idx;
      cyc = cyc + 1;
      e_we = 0; e_start = 0; e_valid = 0; e_last = 0; e_done = 0; e_rd_chk = 0; e_zero = 0;
      if (reset) begin
         mode = 0; n = 0; t_start = -100; t_u0 = -100; e_ovf = 0; e_zero = 1; prev_rdy = 1'b0;
      end else begin
         if (mode == 0) begin
            if (arm) begin
               mode = 1; n = 0; e_ovf = 0; t_start = -100; t_u0 = -100;
            end
         end else if (mode == 1) begin
            if (adc_valid) begin
               e_we      = 1 << (n / BANK_PTS);
               e_addr_wr = n % BANK_PTS;
               e_data    = adc_data;
               if (n == N - 1) begin
                  mode    = 2;
                  t_start = cyc + 1;
               end
               n = n + 1;
            end
         end else begin
            if (adc_valid) e_ovf = 1;
            if (t_u0 < 0 && (cyc - 1) > t_start && fft_rdy && !prev_rdy) t_u0 = cyc;
            if (t_u0 >= 0 && (cyc - 1) == t_u0 + N + 2) mode = 0;
         end
         prev_rdy = fft_rdy;
      end
      if (mode == 2) begin
         if (cyc == t_start) e_start = 1;
         if (t_u0 >= 0) begin
            k = cyc - t_u0;
            if (k >= 0 && k <= N - 1) begin
               e_rd_chk  = 1;
               e_addr_rd = k % BANK_PTS;
            end
            if (k >= 2 && k <= N + 1) begin
               idx     = k - 2;
               e_valid = 1;
               e_idx   = idx;
               e_res   = ramValue(idx / BANK_PTS, idx % BANK_PTS);
               e_last  = (idx == N - 1);
            end
            if (k == N + 2) e_done = 1;
         end
      end
      e_busy = (mode != 0);
      model_ready = 1'b1;
   end

   task automatic checkOutput(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Compare process on the falling edge, plus DUT event logging.
   always @(negedge clk) begin
      if (model_ready) begin
         checkOutput("oWE", {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, e_we);
         checkOutput("oSTART", oSTART, e_start);
         checkOutput("oBUSY", oBUSY, e_busy);
         checkOutput("oOVF", oOVF, e_ovf);
         checkOutput("oRES_VALID", oRES_VALID, e_valid);
         checkOutput("oRES_LAST", oRES_LAST, e_last);
         checkOutput("oDONE", oDONE, e_done);
         if (e_we != 0) begin
            checkOutput("oDATA", oDATA, e_data);
            checkOutput("oADDR_WR_0", addr_wr_0, e_addr_wr);
            checkOutput("oADDR_WR_1", addr_wr_1, e_addr_wr);
            checkOutput("oADDR_WR_2", addr_wr_2, e_addr_wr);
            checkOutput("oADDR_WR_3", addr_wr_3, e_addr_wr);
         end
         if (e_rd_chk) begin
            checkOutput("oADDR_RD_0", addr_rd_0, e_addr_rd);
            checkOutput("oADDR_RD_1", addr_rd_1, e_addr_rd);
            checkOutput("oADDR_RD_2", addr_rd_2, e_addr_rd);
            checkOutput("oADDR_RD_3", addr_rd_3, e_addr_rd);
         end
         if (e_valid) begin
            checkOutput("oRES_INDEX", oRES_INDEX, e_idx);
            checkOutput("oRES_DATA", oRES_DATA, e_res);
         end
         if (e_zero) begin
            checkOutput("reset_oDATA", oDATA, 0);
            checkOutput("reset_oADDR_WR", addr_wr_0, 0);
            checkOutput("reset_oADDR_RD", addr_rd_0, 0);
            checkOutput("reset_oRES_DATA", oRES_DATA, 0);
            checkOutput("reset_oRES_INDEX", oRES_INDEX, 0);
         end
         if (oSTART) start_cyc = cyc;
         if (oWE_0 || oWE_1 || oWE_2 || oWE_3) last_we_cyc = cyc;
         if (oRES_VALID === 1'b1) begin
            if (oRES_INDEX == 0) first_valid_cyc = cyc;
            res_log[oRES_INDEX] = int'(oRES_DATA);
            if (oRES_LAST) last_cyc = cyc;
         end
         if (oDONE) done_cyc = cyc;
      end
   end

   task automatic applyStimulus(input logic rst, input logic a, input logic v,
                                input int d, input logic rdy);
      @(posedge clk);
      #1;
      reset     = rst;
      arm       = a;
      adc_valid = v;
      adc_data  = AW'(d);
      fft_rdy   = rdy;
   endtask

   task automatic clearLog();
      start_cyc = -1; last_we_cyc = -1; first_valid_cyc = -1;
      last_cyc = -1; done_cyc = -1; rise_cyc = -1;
      for (int i = 0; i < N; i++) res_log[i] = -999;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; arm = 1'b0; adc_valid = 1'b0; adc_data = '0; fft_rdy = 1'b0;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 9, 0);   // sample in IDLE is discarded
      applyStimulus(0, 0, 0, 0, 0);

      // Frame 1: contiguous samples, completion edge after a few quiet cycles.
      $display("[TB] frame 1: contiguous load");
      clearLog();
      applyStimulus(0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, i, 0);
      repeat (5) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      rise_cyc = cyc;
      repeat (25) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("f1_start_after_last_we", start_cyc - last_we_cyc, 1);
      checkOutput("f1_valid_after_rise", first_valid_cyc - rise_cyc, 3);
      checkOutput("f1_res0", res_log[0], 0);
      checkOutput("f1_res3", res_log[3], 3);
      checkOutput("f1_res4", res_log[4], 100);
      checkOutput("f1_res15", res_log[15], 303);
      checkOutput("f1_done_after_last", done_cyc - last_cyc, 1);
      checkOutput("f1_busy_after_done", oBUSY, 0);

      // Frame 2: alternate-cycle load, ready already high, overflow in WAIT.
      $display("[TB] frame 2: gapped load, early ready, overflow");
      clearLog();
      applyStimulus(0, 1, 0, 0, 1);
      for (int i = 0; i < N; i++) begin
         applyStimulus(0, 0, 1, -1000 + 137 * i, 1);
         applyStimulus(0, (i == 5), 0, 0, 1);
      end
      repeat (4) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 77, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      rise_cyc = cyc;
      repeat (25) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("f2_start_after_last_we", start_cyc - last_we_cyc, 1);
      checkOutput("f2_valid_after_second_rise", first_valid_cyc - rise_cyc, 3);
      checkOutput("f2_res9", res_log[9], 201);
      checkOutput("f2_ovf_sticky", oOVF, 1);

      // Frame 3: reset at sample 7, then a clean frame from n=0.
      $display("[TB] frame 3: reset mid-load, then full frame");
      clearLog();
      applyStimulus(0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 0, 1, 50 + i, 0);
         if (i == 0) checkOutput("f3_ovf_cleared_by_arm", oOVF, 0);
      end
      applyStimulus(1, 0, 1, 57, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("f3_busy_after_reset", oBUSY, 0);
      applyStimulus(0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 200 + i, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      rise_cyc = cyc;
      repeat (25) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("f3_valid_after_rise", first_valid_cyc - rise_cyc, 3);
      checkOutput("f3_res5", res_log[5], 101);
      checkOutput("f3_done_after_last", done_cyc - last_cyc, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
